vec_store_queue: RTL and testbench

- Upstream neighbour of the vector data memory's write port. Accepts vector store requests from the execute stage: 16 lanes × 16 bit plus a base pixel address.
- Clamps each lane to an 8-bit pixel and range-checks the 16-lane scatter footprint.
- Buffers requests in a small FIFO, then issues at most one memory write per granted cycle.
- Counts completed writes and flags when a full output image has been stored.

---
 rtl/vec_mem_pkg.sv | 22 ++
 rtl/vec_store_queue_if.sv | 28 ++
 rtl/vec_store_queue_pixel_clamp.sv | 18 +
 rtl/vec_store_queue.sv | 157 +++++++++++++++
 tb/tb_vec_store_queue.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and constants for the vector store path
package vec_mem_pkg;

  localparam int LANES            = 16;
  localparam int DEF_IMAGE_WIDTH  = 192;
  localparam int DEF_IMAGE_HEIGHT = 192;
  localparam int DEF_LANE_STRIDE  = 8;
  localparam int DEF_DEPTH        = 4;

  localparam int IMG_PIXELS   = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
  localparam int FRAME_WRITES = IMG_PIXELS / LANES;

  typedef logic [15:0] lane_t;
  typedef lane_t [LANES-1:0] vec_t;
  typedef logic [LANES-1:0][7:0] pix_vec_t;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } qstate_t;

endpackage

// File: rtl/vec_store_queue_if.sv
// rtl/vec_store_queue_if.sv - store request and memory write port bundle
interface vec_store_queue_if;
  import vec_mem_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  vec_t        in_data;
  logic        in_signed;

  logic        mem_grant;
  logic        mem_we;
  logic [15:0] mem_addr;
  vec_t        mem_wd;

  // Queue side: consumes requests and the grant, drives the write port
  modport slave (
    input  in_valid, in_addr, in_data, in_signed, mem_grant,
    output in_ready, mem_we, mem_addr, mem_wd
  );

  // Environment side: execute stage plus memory
  modport master (
    output in_valid, in_addr, in_data, in_signed, mem_grant,
    input  in_ready, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/vec_store_queue_pixel_clamp.sv
// rtl/vec_store_queue_pixel_clamp.sv - saturate one 16-bit lane to an 8-bit pixel
module pixel_clamp (
  input  logic [15:0] lane,
  input  logic        is_signed,
  output logic [7:0]  pix
);

  // Negative signed values floor at 0; anything above 255 saturates
  always_comb begin
    pix = lane[7:0];
    if (is_signed && lane[15]) begin
      pix = 8'h00;
    end else if (lane[15:8] != 8'h00) begin
      pix = 8'hFF;
    end
  end

endmodule

// File: rtl/vec_store_queue.sv
// rtl/vec_store_queue.sv - clamping, range-checked vector store FIFO with frame counter
module vec_store_queue
  import vec_mem_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int LANE_STRIDE  = DEF_LANE_STRIDE,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic                CLK,
  input  logic                RST_N,
  vec_store_queue_if.slave    bus,
  input  logic                frame_clear,
  output logic [15:0]         wr_count,
  output logic                addr_err,
  output logic                frame_done
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int PIXELS  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int FRAME_W = PIXELS / LANES;
  localparam int SPAN    = (LANES - 1) * LANE_STRIDE;

  qstate_t         state_q, state_d;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  pix_vec_t        data_q [DEPTH];
  logic [15:0]     addr_q [DEPTH];
  pix_vec_t        pix_in;
  logic [16:0]     end_addr;
  logic            range_ok;
  logic            full, empty, run;
  logic            push_hs, push, pop;
  logic            enter_done;
  logic [15:0]     wr_count_q;
  logic            addr_err_q;
  logic            frame_done_q;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_clamp
      pixel_clamp u_clamp (
        .lane      (bus.in_data[g]),
        .is_signed (bus.in_signed),
        .pix       (pix_in[g])
      );
    end
  endgenerate

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign run   = (state_q == RUN);

  // in_ready depends only on registered state, never on mem_grant
  assign bus.in_ready = !full && run;
  assign bus.mem_we   = !empty && bus.mem_grant && run;

  // Footprint end address is formed in 17 bits so high bases cannot wrap into range
  assign end_addr = {1'b0, bus.in_addr} + 17'(SPAN);
  assign range_ok = (end_addr <= 17'(PIXELS - 1));
  assign push_hs  = bus.in_valid && bus.in_ready;
  assign push     = push_hs && range_ok;
  assign pop      = bus.mem_we;

  // Head entry drives the write port; zeros while the queue is empty
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_wd   = '0;
    if (!empty) begin
      bus.mem_addr = addr_q[rd_ptr];
      for (int i = 0; i < LANES; i++) begin
        bus.mem_wd[i] = {8'h00, data_q[rd_ptr][i]};
      end
    end
  end

  // Entry storage is only meaningful while occupancy covers it, so it has no reset
  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[wr_ptr] <= pix_in;
      addr_q[wr_ptr] <= bus.in_addr;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write counter and sticky range error; a frame clear overrides a same-cycle pop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_count_q <= '0;
      addr_err_q <= 1'b0;
    end else if (frame_clear) begin
      wr_count_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (pop) wr_count_q <= wr_count_q + 16'd1;
      if (push_hs && !range_ok) addr_err_q <= 1'b1;
    end
  end

  // Frame state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Enter DONE on the pop that completes the frame; leave on frame_clear
  always_comb begin
    state_d    = state_q;
    enter_done = 1'b0;
    case (state_q)
      RUN: begin
        if (!frame_clear && pop && (wr_count_q == 16'(FRAME_W - 1))) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        if (frame_clear) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // One-cycle completion pulse in the cycle after the final write
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= enter_done;
    end
  end

  assign wr_count   = wr_count_q;
  assign addr_err   = addr_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vec_store_queue.sv
// tb/tb_vec_store_queue.sv - directed self-checking bench for vec_store_queue
module tb_vec_store_queue;
  import vec_mem_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        frame_clear;
  logic [15:0] wr_count;
  logic        addr_err;
  logic        frame_done;

  vec_store_queue_if vif ();

  vec_store_queue dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (vif),
    .frame_clear (frame_clear),
    .wr_count    (wr_count),
    .addr_err    (addr_err),
    .frame_done  (frame_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_lanes(input logic [15:0] v);
    for (int j = 0; j < LANES; j++) vif.in_data[j] = v;
  endtask

  typedef struct {
    logic        sgn;
    logic [15:0] addr;
    logic [15:0] l0, l1, l2;
    logic        exp_we;
    logic [7:0]  e0, e1, e2;
    logic        exp_err;
  } vec_rec_t;

  vec_rec_t tbl [6];
  int       exp_wr;
  logic [15:0] q [$];
  int pops, pulses, order_bad, pushed, lane_bad;
  logic hs;

  initial begin
    tbl[0] = '{1'b1, 16'd0,     16'hFFFB, 16'd300,  16'd128,  1'b1, 8'd0,   8'd255, 8'd128, 1'b0};
    tbl[1] = '{1'b0, 16'd0,     16'hFFFB, 16'd300,  16'd128,  1'b1, 8'd255, 8'd255, 8'd128, 1'b0};
    tbl[2] = '{1'b1, 16'd36744, 16'd1,    16'd2,    16'd3,    1'b0, 8'd0,   8'd0,   8'd0,   1'b1};
    tbl[3] = '{1'b1, 16'd36743, 16'h00FF, 16'h0100, 16'h8000, 1'b1, 8'd255, 8'd255, 8'd0,   1'b0};
    tbl[4] = '{1'b0, 16'd1234,  16'h0000, 16'h00FF, 16'h7FFF, 1'b1, 8'd0,   8'd255, 8'd255, 1'b0};
    tbl[5] = '{1'b1, 16'hFFFF,  16'd7,    16'd8,    16'd9,    1'b0, 8'd0,   8'd0,   8'd0,   1'b1};

    RST_N = 1'b0;
    frame_clear = 1'b0;
    vif.in_valid = 1'b0;
    vif.in_addr = '0;
    vif.in_data = '0;
    vif.in_signed = 1'b0;
    vif.mem_grant = 1'b0;
    exp_wr = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    vif.mem_grant = 1'b1;
    #1;
    chk("rst_in_ready", vif.in_ready, 1);
    chk("rst_mem_we", vif.mem_we, 0);
    chk("rst_mem_addr", vif.mem_addr, 0);
    chk("rst_mem_wd_zero", (vif.mem_wd == '0), 1);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_frame_done", frame_done, 0);

    // Table: one push per vector, grant held high
    step();
    for (int i = 0; i < 6; i++) begin
      vif.in_signed = tbl[i].sgn;
      vif.in_addr   = tbl[i].addr;
      for (int j = 3; j < LANES; j++) vif.in_data[j] = 16'(j * 10);
      vif.in_data[0] = tbl[i].l0;
      vif.in_data[1] = tbl[i].l1;
      vif.in_data[2] = tbl[i].l2;
      vif.mem_grant = 1'b1;
      vif.in_valid  = 1'b1;
      step();
      vif.in_valid = 1'b0;
      chk($sformatf("tbl%0d_mem_we", i), vif.mem_we, tbl[i].exp_we);
      chk($sformatf("tbl%0d_addr_err", i), addr_err, tbl[i].exp_err);
      if (tbl[i].exp_we) begin
        chk($sformatf("tbl%0d_mem_addr", i), vif.mem_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_lane0", i), vif.mem_wd[0], {8'h00, tbl[i].e0});
        chk($sformatf("tbl%0d_lane1", i), vif.mem_wd[1], {8'h00, tbl[i].e1});
        chk($sformatf("tbl%0d_lane2", i), vif.mem_wd[2], {8'h00, tbl[i].e2});
        lane_bad = 0;
        for (int j = 3; j < LANES; j++) if (vif.mem_wd[j] !== 16'(j * 10)) lane_bad++;
        chk($sformatf("tbl%0d_lanes_rest_bad", i), lane_bad, 0);
        exp_wr++;
      end
      step();
      chk($sformatf("tbl%0d_wr_count", i), wr_count, exp_wr);
      chk($sformatf("tbl%0d_drained_we", i), vif.mem_we, 0);
      if (tbl[i].exp_err) begin
        frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
        exp_wr = 0;
        chk($sformatf("tbl%0d_err_cleared", i), addr_err, 0);
        chk($sformatf("tbl%0d_count_cleared", i), wr_count, 0);
      end
    end

    // Backpressure: fill with grant low, then drain in order
    vif.mem_grant = 1'b0;
    vif.in_signed = 1'b0;
    for (int p = 0; p < 4; p++) begin
      vif.in_addr = 16'(100 * (p + 1));
      fill_lanes(16'(p + 1));
      vif.in_valid = 1'b1;
      step();
    end
    vif.in_valid = 1'b0;
    chk("bp_full_in_ready", vif.in_ready, 0);
    chk("bp_no_grant_we", vif.mem_we, 0);
    vif.mem_grant = 1'b1;
    for (int p = 0; p < 4; p++) begin
      #1;
      chk($sformatf("bp_pop%0d_we", p), vif.mem_we, 1);
      chk($sformatf("bp_pop%0d_addr", p), vif.mem_addr, 100 * (p + 1));
      chk($sformatf("bp_pop%0d_lane", p), vif.mem_wd[LANES-1], p + 1);
      step();
      if (p == 0) chk("bp_ready_after_pop", vif.in_ready, 1);
      exp_wr++;
    end
    chk("bp_empty_we", vif.mem_we, 0);
    chk("bp_wr_count", wr_count, exp_wr);

    // Concurrent push and pop at occupancy 2
    vif.mem_grant = 1'b0;
    vif.in_valid = 1'b1;
    vif.in_addr = 16'd500; step();
    vif.in_addr = 16'd600; step();
    vif.in_addr = 16'd700;
    vif.mem_grant = 1'b1;
    #1;
    chk("cc_head_500", vif.mem_addr, 500);
    chk("cc_we", vif.mem_we, 1);
    step();
    vif.in_valid = 1'b0;
    chk("cc_head_600", vif.mem_addr, 600);
    chk("cc_ready", vif.in_ready, 1);
    step();
    chk("cc_head_700", vif.mem_addr, 700);
    chk("cc_we_700", vif.mem_we, 1);
    step();
    chk("cc_empty", vif.mem_we, 0);
    exp_wr += 3;
    chk("cc_wr_count", wr_count, exp_wr);

    // Full frame: stream until the frame completes
    frame_clear = 1'b1; step(); frame_clear = 1'b0;
    chk("fr_cleared", wr_count, 0);
    q.delete();
    pops = 0; pulses = 0; order_bad = 0; pushed = 0;
    vif.in_addr = 16'd0;
    vif.mem_grant = 1'b1;
    vif.in_valid = 1'b1;
    for (int c = 0; c < 3000 && pops < 2304; c++) begin
      @(negedge CLK);
      if (frame_done) pulses++;
      if (vif.mem_we) begin
        if (q.size() == 0 || vif.mem_addr !== q[0]) order_bad++;
        if (q.size() != 0) void'(q.pop_front());
        pops++;
      end
      hs = vif.in_valid && vif.in_ready;
      if (hs) q.push_back(vif.in_addr);
      step();
      if (hs) begin
        pushed++;
        vif.in_addr = 16'((pushed % 2000) * 16);
      end
      if (pops == 2304) vif.in_valid = 1'b0;
    end
    vif.in_valid = 1'b0;
    chk("fr_pops_in_budget", pops, 2304);
    chk("fr_order_bad", order_bad, 0);
    chk("fr_early_pulse", pulses, 0);
    chk("fr_done_pulse", frame_done, 1);
    chk("fr_wr_count", wr_count, 2304);
    chk("fr_in_ready", vif.in_ready, 0);
    chk("fr_no_we", vif.mem_we, 0);
    chk("fr_pending", q.size(), 1);
    step();
    chk("fr_pulse_once", frame_done, 0);
    repeat (3) step();
    chk("fr_hold_we", vif.mem_we, 0);
    chk("fr_hold_count", wr_count, 2304);
    frame_clear = 1'b1; step(); frame_clear = 1'b0;
    chk("fr_clr_count", wr_count, 0);
    chk("fr_clr_we", vif.mem_we, 1);
    chk("fr_clr_addr", vif.mem_addr, (q.size() != 0) ? q[0] : 16'hDEAD);
    step();
    chk("fr_after_count", wr_count, 1);
    chk("fr_after_empty", vif.mem_we, 0);

    // Asynchronous reset with three queued entries
    vif.mem_grant = 1'b0;
    vif.in_valid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      vif.in_addr = 16'(800 + 100 * p);
      step();
    end
    vif.in_valid = 1'b0;
    @(negedge CLK);
    vif.mem_grant = 1'b1;
    #1;
    chk("rs_pre_we", vif.mem_we, 1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("rs_async_we", vif.mem_we, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rs_post_we", vif.mem_we, 0);
    chk("rs_post_addr", vif.mem_addr, 0);
    chk("rs_post_count", wr_count, 0);
    chk("rs_post_ready", vif.in_ready, 1);
    @(negedge CLK);
    chk("rs_still_empty", vif.mem_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
